// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: arbitrates trap / EX-branch / ID-jump redirects onto the PC,
// parks a redirect that arrives while the PC is stalled, and raises IF/ID flush strobes
// for a fixed window after every applied redirect.
module fetch_redirect_ctrl #(
  parameter int VECT_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int COUNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               trap_req,
  input  logic [VECT_W-1:0]  trap_vect,
  input  logic               br_req,
  input  logic [VECT_W-1:0]  br_vect,
  input  logic               jmp_req,
  input  logic [VECT_W-1:0]  jmp_vect,
  input  logic               hz_stall,
  input  logic               imem_ready,
  output logic               pc_stall,
  output logic               pc_jump_en,
  output logic [VECT_W-1:0]  pc_jump_vect,
  output logic               flush_if,
  output logic               flush_id,
  output logic [1:0]         redir_src,
  output logic               misalign_err,
  output logic [COUNT_W-1:0] redir_count
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [1:0] SRC_TRAP = 2'd0;
  localparam logic [1:0] SRC_BR   = 2'd1;
  localparam logic [1:0] SRC_JMP  = 2'd2;
  localparam logic [1:0] SRC_NONE = 2'd3;

  // A single-cycle flush window never needs the FLUSH state.
  localparam logic [1:0] ST_AFTER_APPLY = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
  localparam int         CNT_W          = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic [1:0]         pend_src_q;
  logic [VECT_W-1:0]  pend_vect_q;

  logic               stall_c;
  logic               req_br, req_jmp;
  logic               win_v;
  logic [1:0]         win_src;
  logic [VECT_W-1:0]  win_vect;
  logic               cand_v;
  logic [1:0]         cand_src;
  logic [VECT_W-1:0]  cand_vect;
  logic               apply;
  logic               in_flush;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    sat_inc = (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
  endfunction

  assign stall_c  = hz_stall | ~imem_ready;
  assign pc_stall = stall_c;

  // Pick the redirect candidate: fixed-priority winner, or the parked one unless outranked.
  always_comb begin
    // Branch/jump requests during a flush belong to squashed younger instructions.
    req_br   = br_req  & (state_q != ST_FLUSH);
    req_jmp  = jmp_req & (state_q != ST_FLUSH);
    win_v    = 1'b0;
    win_src  = SRC_NONE;
    win_vect = '0;
    if (trap_req) begin
      win_v    = 1'b1;
      win_src  = SRC_TRAP;
      win_vect = trap_vect;
    end else if (req_br) begin
      win_v    = 1'b1;
      win_src  = SRC_BR;
      win_vect = br_vect;
    end else if (req_jmp) begin
      win_v    = 1'b1;
      win_src  = SRC_JMP;
      win_vect = jmp_vect;
    end
    cand_v    = win_v;
    cand_src  = win_src;
    cand_vect = win_vect;
    if (state_q == ST_HOLD) begin
      cand_v    = 1'b1;
      cand_src  = pend_src_q;
      cand_vect = pend_vect_q;
      if (win_v && (win_src < pend_src_q)) begin
        cand_src  = win_src;
        cand_vect = win_vect;
      end
    end
  end

  // Outputs are forced idle while reset is held so a live request cannot leak through.
  assign apply        = reset_n & cand_v & ~stall_c;
  assign in_flush     = reset_n & (state_q == ST_FLUSH);
  assign pc_jump_en   = apply;
  assign pc_jump_vect = apply ? {cand_vect[VECT_W-1:2], 2'b00} : '0;
  assign flush_if     = apply | in_flush;
  // A jump stays in ID, so only trap/branch squash the ID/EX register.
  assign flush_id     = (apply & (cand_src != SRC_JMP)) | (in_flush & (redir_src != SRC_JMP));

  // Next state and flush-window counter.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (apply) begin
      state_d = ST_AFTER_APPLY;
      fcnt_d  = CNT_LOAD;
    end else if (cand_v) begin
      state_d = ST_HOLD;
      fcnt_d  = '0;
    end else if (state_q == ST_FLUSH) begin
      fcnt_d  = fcnt_q - CNT_W'(1);
      if (fcnt_q == CNT_W'(1)) begin
        state_d = ST_RUN;
      end
    end
  end

  // State, parked redirect and redirect bookkeeping registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      fcnt_q       <= '0;
      pend_src_q   <= SRC_NONE;
      pend_vect_q  <= '0;
      redir_src    <= SRC_NONE;
      redir_count  <= '0;
      misalign_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      misalign_err <= apply & (cand_vect[1:0] != 2'b00);
      if (cand_v && !apply) begin
        pend_src_q  <= cand_src;
        pend_vect_q <= cand_vect;
      end
      if (apply) begin
        redir_src   <= cand_src;
        redir_count <= sat_inc(redir_count);
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed redirect scenarios with literal expectations,
// plus a cycle-by-cycle reference model compared on every falling edge.
module tb_fetch_redirect_ctrl;

  localparam int VW = 32;
  localparam int FC = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          trap_req = 1'b0, br_req = 1'b0, jmp_req = 1'b0;
  logic [VW-1:0] trap_vect = '0, br_vect = '0, jmp_vect = '0;
  logic          hz_stall = 1'b0, imem_ready = 1'b1;
  logic          pc_stall, pc_jump_en, flush_if, flush_id, misalign_err;
  logic [VW-1:0] pc_jump_vect;
  logic [1:0]    redir_src;
  logic [CW-1:0] redir_count;

  int checks = 0;
  int errors = 0;

  fetch_redirect_ctrl #(.VECT_W(VW), .FLUSH_CYCLES(FC), .COUNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .trap_req(trap_req), .trap_vect(trap_vect),
    .br_req(br_req), .br_vect(br_vect),
    .jmp_req(jmp_req), .jmp_vect(jmp_vect),
    .hz_stall(hz_stall), .imem_ready(imem_ready),
    .pc_stall(pc_stall), .pc_jump_en(pc_jump_en), .pc_jump_vect(pc_jump_vect),
    .flush_if(flush_if), .flush_id(flush_id), .redir_src(redir_src),
    .misalign_err(misalign_err), .redir_count(redir_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model state: parked redirect, remaining flush cycles after the apply cycle,
  // last applied source, redirect count, pending misalign pulse.
  bit          m_pv = 0;
  int          m_ps = 3;
  logic [31:0] m_pvect = '0;
  int          m_fl = 0;
  int          m_last = 3;
  int          m_cnt = 0;
  bit          m_mis = 0;
  bit          n_pv;
  int          n_ps, n_fl, n_last, n_cnt;
  logic [31:0] n_pvect;
  bit          n_mis;

  always @(negedge clk) begin
    bit          e_stall, e_je, e_fif, e_fid, best_v, cand_v;
    int          best_s, cand_s;
    logic [31:0] best_vect, cand_vect, e_vect;
    e_stall = hz_stall || !imem_ready;
    e_je = 0; e_vect = '0; e_fif = 0; e_fid = 0;
    if (!reset_n) begin
      m_pv = 0; m_ps = 3; m_pvect = '0; m_fl = 0; m_last = 3; m_cnt = 0; m_mis = 0;
      n_pv = 0; n_ps = 3; n_pvect = '0; n_fl = 0; n_last = 3; n_cnt = 0; n_mis = 0;
    end else begin
      best_v = 1; best_s = 0; best_vect = trap_vect;
      if (trap_req) begin best_s = 0; best_vect = trap_vect; end
      else if (br_req && m_fl == 0) begin best_s = 1; best_vect = br_vect; end
      else if (jmp_req && m_fl == 0) begin best_s = 2; best_vect = jmp_vect; end
      else best_v = 0;
      cand_v = best_v; cand_s = best_s; cand_vect = best_vect;
      if (m_pv) begin
        cand_v = 1; cand_s = m_ps; cand_vect = m_pvect;
        if (best_v && best_s < m_ps) begin cand_s = best_s; cand_vect = best_vect; end
      end
      n_pv = m_pv; n_ps = m_ps; n_pvect = m_pvect; n_fl = m_fl;
      n_last = m_last; n_cnt = m_cnt; n_mis = 0;
      if (cand_v && !e_stall) begin
        e_je = 1; e_vect = cand_vect & 32'hFFFF_FFFC; e_fif = 1; e_fid = (cand_s != 2);
        n_pv = 0; n_fl = FC - 1; n_last = cand_s;
        n_cnt = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
        n_mis = (cand_vect[1:0] != 2'b00);
      end else begin
        e_fif = (m_fl > 0);
        e_fid = (m_fl > 0) && (m_last != 2);
        if (cand_v) begin
          n_pv = 1; n_ps = cand_s; n_pvect = cand_vect; n_fl = 0;
        end else if (m_fl > 0) begin
          n_fl = m_fl - 1;
        end
      end
    end
    chk("m_pc_stall", 64'(pc_stall), 64'(e_stall));
    chk("m_jump_en", 64'(pc_jump_en), 64'(e_je));
    chk("m_jump_vect", 64'(pc_jump_vect), 64'(e_vect));
    chk("m_flush_if", 64'(flush_if), 64'(e_fif));
    chk("m_flush_id", 64'(flush_id), 64'(e_fid));
    chk("m_redir_src", 64'(redir_src), 64'(m_last));
    chk("m_redir_count", 64'(redir_count), 64'(m_cnt));
    chk("m_misalign", 64'(misalign_err), 64'(m_mis));
  end

  always @(posedge clk) begin
    if (reset_n) begin
      m_pv = n_pv; m_ps = n_ps; m_pvect = n_pvect; m_fl = n_fl;
      m_last = n_last; m_cnt = n_cnt; m_mis = n_mis;
    end
  end

  // One cycle of stimulus; returns at the falling edge so the caller can check that cycle.
  task automatic step(input logic t, input logic b, input logic j,
                      input logic [31:0] tv, input logic [31:0] bv, input logic [31:0] jv,
                      input logic hz, input logic rdy);
    @(posedge clk);
    #1;
    trap_req = t; br_req = b; jmp_req = j;
    trap_vect = tv; br_vect = bv; jmp_vect = jv;
    hz_stall = hz; imem_ready = rdy;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1);
  endtask

  initial begin
    // Reset: a live request must not reach the PC.
    step(0, 1, 0, 32'h0, 32'h100, 32'h0, 0, 1);
    chk("rst_je", 64'(pc_jump_en), 64'd0);
    chk("rst_src", 64'(redir_src), 64'd3);
    chk("rst_cnt", 64'(redir_count), 64'd0);
    chk("rst_fif", 64'(flush_if), 64'd0);
    idle();
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle();

    // 1: unstalled branch
    step(0, 1, 0, 32'h0, 32'h100, 32'h0, 0, 1);
    chk("t1_je", 64'(pc_jump_en), 64'd1);
    chk("t1_vect", 64'(pc_jump_vect), 64'h100);
    chk("t1_fid", 64'(flush_id), 64'd1);
    idle();
    chk("t1_fif2", 64'(flush_if), 64'd1);
    chk("t1_fid2", 64'(flush_id), 64'd1);
    chk("t1_src", 64'(redir_src), 64'd1);
    chk("t1_cnt", 64'(redir_count), 64'd1);
    idle();
    chk("t1_fif3", 64'(flush_if), 64'd0);

    // 2: jump held through three hazard-stall cycles
    step(0, 0, 1, 32'h0, 32'h0, 32'h40, 1, 1);
    chk("t2_je_stall", 64'(pc_jump_en), 64'd0);
    chk("t2_pc_stall", 64'(pc_stall), 64'd1);
    step(0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 1);
    step(0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 1);
    chk("t2_je_stall3", 64'(pc_jump_en), 64'd0);
    idle();
    chk("t2_je", 64'(pc_jump_en), 64'd1);
    chk("t2_vect", 64'(pc_jump_vect), 64'h40);
    chk("t2_fid", 64'(flush_id), 64'd0);
    idle();
    chk("t2_fid2", 64'(flush_id), 64'd0);
    chk("t2_src", 64'(redir_src), 64'd2);
    idle();

    // 3: parked jump outranked by a branch during an imem stall
    step(0, 0, 1, 32'h0, 32'h0, 32'h40, 0, 0);
    chk("t3_je_stall", 64'(pc_jump_en), 64'd0);
    step(0, 1, 0, 32'h0, 32'h80, 32'h0, 0, 0);
    idle();
    chk("t3_vect", 64'(pc_jump_vect), 64'h80);
    idle();
    chk("t3_src", 64'(redir_src), 64'd1);
    chk("t3_cnt", 64'(redir_count), 64'd3);
    idle();
    chk("t3_no_jmp", 64'(pc_jump_en), 64'd0);

    // 4: all three requests together
    step(1, 1, 1, 32'h8, 32'h100, 32'h200, 0, 1);
    chk("t4_vect", 64'(pc_jump_vect), 64'h8);
    idle();
    chk("t4_src", 64'(redir_src), 64'd0);
    idle();
    chk("t4_no_later", 64'(pc_jump_en), 64'd0);

    // 5: branch ignored during flush, trap honoured and restarts the flush
    step(0, 1, 0, 32'h0, 32'h100, 32'h0, 0, 1);
    step(0, 1, 0, 32'h0, 32'h200, 32'h0, 0, 1);
    chk("t5_br_ignored", 64'(pc_jump_en), 64'd0);
    chk("t5_fif", 64'(flush_if), 64'd1);
    idle();
    chk("t5_fif_end", 64'(flush_if), 64'd0);
    step(0, 1, 0, 32'h0, 32'h104, 32'h0, 0, 1);
    step(1, 0, 0, 32'h10, 32'h0, 32'h0, 0, 1);
    chk("t5_trap_je", 64'(pc_jump_en), 64'd1);
    chk("t5_trap_vect", 64'(pc_jump_vect), 64'h10);
    idle();
    chk("t5_restart_fif", 64'(flush_if), 64'd1);
    chk("t5_cnt", 64'(redir_count), 64'd7);
    idle();
    chk("t5_fif_done", 64'(flush_if), 64'd0);

    // 6: misaligned vector, counter saturation, reset in the middle of HOLD
    step(0, 1, 0, 32'h0, 32'h103, 32'h0, 0, 1);
    chk("t6_vect", 64'(pc_jump_vect), 64'h100);
    idle();
    chk("t6_mis", 64'(misalign_err), 64'd1);
    chk("t6_sat", 64'(redir_count), 64'd7);
    idle();
    chk("t6_mis_off", 64'(misalign_err), 64'd0);
    step(0, 0, 1, 32'h0, 32'h0, 32'h44, 1, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    jmp_req = 1'b0;
    @(negedge clk);
    chk("t6_rst_src", 64'(redir_src), 64'd3);
    chk("t6_rst_cnt", 64'(redir_count), 64'd0);
    chk("t6_rst_je", 64'(pc_jump_en), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    hz_stall = 1'b0;
    @(negedge clk);
    chk("t6_pend_lost", 64'(pc_jump_en), 64'd0);
    idle();
    chk("t6_pend_lost2", 64'(pc_jump_en), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
